// File: rtl/tlb_refill_walker.sv
// ============================================================================
// Module   : tlb_refill_walker
// Brief    : Two-level page-table walker that refills a TLB on a miss and
//            raises a one-cycle page fault on an invalid PTE.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tlb_refill_walker #(
    parameter int OFFSET  = 12,
    parameter int L1_BITS = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  tlb_miss_i,
    input  logic [32-OFFSET-1:0]  miss_virtual_page_i,
    input  logic [31:0]           ptbr_i,
    output logic                  mem_req_o,
    output logic [31:0]           mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic [31:0]           mem_data_i,
    output logic [32-OFFSET-1:0]  w_virtual_page_o,
    output logic [32-OFFSET-1:0]  w_phys_page_o,
    output logic                  write_enable_o,
    output logic                  busy_o,
    output logic                  page_fault_o,
    output logic [32-OFFSET-1:0]  fault_virtual_page_o
);

    localparam int PN      = 32 - OFFSET;
    localparam int L2_BITS = PN - L1_BITS;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_L1         = 3'd1,
        ST_L2         = 3'd2,
        ST_REFILL     = 3'd3,
        ST_SETTLE     = 3'd4,
        ST_FAULT      = 3'd5,
        ST_FAULT_HOLD = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PN-1:0]   r_vpn;
    logic [PN-1:0]   r_ptbr_pn;
    logic [PN-1:0]   r_l1_ppn;
    logic [PN-1:0]   r_ppn;
    logic [PN-1:0]   r_fault_vpn;
    logic            w_latch_miss;
    logic            w_latch_l1;
    logic            w_latch_l2;
    logic            w_enter_fault;
    logic [31:0]     w_l1_addr;
    logic [31:0]     w_l2_addr;
    logic            w_unused_bits;

    // Only the page-number field of the base and the valid bit of a PTE matter.
    assign w_unused_bits = ^{ptbr_i[OFFSET-1:0], mem_data_i[OFFSET-1:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_latch_miss  = 1'b0;
        w_latch_l1    = 1'b0;
        w_latch_l2    = 1'b0;
        w_enter_fault = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tlb_miss_i) begin
                    w_latch_miss = 1'b1;
                    w_next       = ST_L1;
                end
            end
            ST_L1: begin
                if (mem_ready_i) begin
                    if (mem_data_i[0]) begin
                        w_latch_l1 = 1'b1;
                        w_next     = ST_L2;
                    end else begin
                        w_enter_fault = 1'b1;
                        w_next        = ST_FAULT;
                    end
                end
            end
            ST_L2: begin
                if (mem_ready_i) begin
                    if (mem_data_i[0]) begin
                        w_latch_l2 = 1'b1;
                        w_next     = ST_REFILL;
                    end else begin
                        w_enter_fault = 1'b1;
                        w_next        = ST_FAULT;
                    end
                end
            end
            ST_REFILL:     w_next = ST_SETTLE;
            ST_SETTLE:     w_next = ST_IDLE;
            ST_FAULT:      w_next = ST_FAULT_HOLD;
            ST_FAULT_HOLD: if (!tlb_miss_i) w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // Walk context is captured once so input changes mid-walk cannot disturb it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vpn       <= '0;
            r_ptbr_pn   <= '0;
            r_l1_ppn    <= '0;
            r_ppn       <= '0;
            r_fault_vpn <= '0;
        end else begin
            if (w_latch_miss) begin
                r_vpn     <= miss_virtual_page_i;
                r_ptbr_pn <= ptbr_i[31:OFFSET];
            end
            if (w_latch_l1) begin
                r_l1_ppn <= mem_data_i[31:OFFSET];
            end
            if (w_latch_l2) begin
                r_ppn <= mem_data_i[31:OFFSET];
            end
            if (w_enter_fault) begin
                r_fault_vpn <= r_vpn;
            end
        end
    end

    // 32-bit sums; any carry out of bit 31 is dropped.
    assign w_l1_addr = {r_ptbr_pn, {OFFSET{1'b0}}} + (32'(r_vpn[PN-1:L2_BITS]) << 2);
    assign w_l2_addr = {r_l1_ppn,  {OFFSET{1'b0}}} + (32'(r_vpn[L2_BITS-1:0]) << 2);

    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        case (r_state)
            ST_L1: begin
                mem_req_o  = 1'b1;
                mem_addr_o = w_l1_addr;
            end
            ST_L2: begin
                mem_req_o  = 1'b1;
                mem_addr_o = w_l2_addr;
            end
            default: begin
                mem_req_o  = 1'b0;
                mem_addr_o = '0;
            end
        endcase
    end

    assign write_enable_o       = (r_state == ST_REFILL);
    assign w_virtual_page_o     = write_enable_o ? r_vpn : '0;
    assign w_phys_page_o        = write_enable_o ? r_ppn : '0;
    assign busy_o               = (r_state != ST_IDLE);
    assign page_fault_o         = (r_state == ST_FAULT);
    assign fault_virtual_page_o = r_fault_vpn;

endmodule

`default_nettype wire
